// File: rtl/interrupt_claim_complete.sv
// Interrupt claim/complete controller: priority arbiter, threshold register,
// and a single-outstanding-claim FSM driving the core interrupt line.
//
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   pending_interrupts        : pending bit per source (ID k+1 is bit k)
//   interrupt_priority_regs   : 32-bit priority per source, bits [2:0] used
//   active_interrupt          : one-hot mask of the source in service
//   interrupt_claimed         : one-cycle pulse after an accepted claim
//   interrupt_service_request : interrupt line to the core
//   threshold_addr/claim_addr : register addresses
//   addr/wen/ren/wdata        : register access request
//   rdata/addr_valid          : register read data and address hit
module interrupt_claim_complete #(
    parameter int N_interrupts = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_interrupts-1:0]      pending_interrupts,
    input  logic [N_interrupts-1:0][31:0] interrupt_priority_regs,
    output logic [N_interrupts-1:0]      active_interrupt,
    output logic                         interrupt_claimed,
    output logic                         interrupt_service_request,
    input  logic [31:0]                  threshold_addr,
    input  logic [31:0]                  claim_addr,
    input  logic [31:0]                  addr,
    input  logic                         wen,
    input  logic                         ren,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata,
    output logic                         addr_valid
);

    localparam int IDW = $clog2(N_interrupts + 1);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        CLAIMED
    } state_t;

    state_t state_q, state_d;

    logic [2:0]     thr_q, thr_d;
    logic [IDW-1:0] best_id_q, arb_id;
    logic [2:0]     best_prio_q, arb_prio;
    logic [IDW-1:0] claimed_id_q, claimed_id_d;
    logic           pulse_q, pulse_d;

    logic hit_thr, hit_claim;
    logic claim_rd, complete_wr, eligible;

    logic [N_interrupts-1:0] prio_hi_unused;

    assign hit_thr   = (addr == threshold_addr);
    assign hit_claim = (addr == claim_addr);
    assign addr_valid = hit_thr || hit_claim;

    // A simultaneous read and write is treated purely as a write.
    assign claim_rd    = ren && !wen && hit_claim;
    assign complete_wr = wen && hit_claim &&
                         (wdata == 32'(claimed_id_q));

    assign eligible = (best_id_q != '0) && (best_prio_q > thr_q);

    // Strict '>' keeps the lowest ID on ties; priority 0 never wins.
    always_comb begin
        arb_id   = '0;
        arb_prio = '0;
        for (int k = 0; k < N_interrupts; k++) begin
            if (pending_interrupts[k] &&
                interrupt_priority_regs[k][2:0] > arb_prio) begin
                arb_id   = IDW'(k + 1);
                arb_prio = interrupt_priority_regs[k][2:0];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_interrupts; k++) begin
            prio_hi_unused[k] = |interrupt_priority_regs[k][31:3];
        end
    end

    always_comb begin
        state_d      = state_q;
        claimed_id_d = claimed_id_q;
        pulse_d      = 1'b0;
        thr_d        = thr_q;
        if (wen && hit_thr) begin
            thr_d = wdata[2:0];
        end
        unique case (state_q)
            IDLE: begin
                if (eligible) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (claim_rd) begin
                    state_d      = CLAIMED;
                    claimed_id_d = best_id_q;
                    pulse_d      = 1'b1;
                end else if (!eligible) begin
                    state_d = IDLE;
                end
            end
            CLAIMED: begin
                if (complete_wr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            thr_q        <= '0;
            best_id_q    <= '0;
            best_prio_q  <= '0;
            claimed_id_q <= '0;
            pulse_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            thr_q        <= thr_d;
            best_id_q    <= arb_id;
            best_prio_q  <= arb_prio;
            claimed_id_q <= claimed_id_d;
            pulse_q      <= pulse_d;
        end
    end

    assign interrupt_claimed         = pulse_q;
    assign interrupt_service_request = (state_q == PENDING);

    always_comb begin
        active_interrupt = '0;
        if (state_q == CLAIMED) begin
            for (int k = 0; k < N_interrupts; k++) begin
                if (claimed_id_q == IDW'(k + 1)) begin
                    active_interrupt[k] = 1'b1;
                end
            end
        end
    end

    // Claim reads return 0 outside PENDING: only one claim outstanding.
    always_comb begin
        rdata = '0;
        if (hit_claim) begin
            if (state_q == PENDING) begin
                rdata = 32'(best_id_q);
            end
        end else if (hit_thr) begin
            rdata = {29'b0, thr_q};
        end
    end

endmodule
